seq_mult16_core8: RTL and testbench

//  Multi-cycle 16x16 unsigned multiplier built around ONE instance of the 8x8 array

---
 rtl/seq_mult16_core8.sv | 127 ++++++++++++
 tb/tb_seq_mult16_core8.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult16_core8.sv
// 16x16 unsigned multiplier time-sharing one 8x8 core; result 5 (REG_CORE=0) or 6 (REG_CORE=1) cycles after accept.
// Backpressure: operands accepted only in IDLE; the result holds in DONE until out_ready.

module array_8 (
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    output logic [15:0] prod
);
    always_comb begin
        prod = '0;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) prod = prod + ({8'b0, x} << i);
        end
    end
endmodule

module seq_mult16_core8 #(
    parameter int REG_CORE = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] p,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, MUL, FLUSH, DONE} state_t;

    state_t      state;
    logic [1:0]  pass;
    logic [15:0] a_q, b_q;
    logic [31:0] acc;
    logic [15:0] prod_q;
    logic [4:0]  shift_q;

    logic [7:0]  core_x, core_y;
    logic [15:0] prod16;
    logic [4:0]  shift;
    logic [31:0] term_now, term_q, acc_add;

    array_8 u_core (.x(core_x), .y(core_y), .prod(prod16));

    always_comb begin
        core_x = a_q[7:0];
        core_y = b_q[7:0];
        shift  = 5'd0;
        case (pass)
            2'd1: begin core_x = a_q[15:8]; core_y = b_q[7:0];  shift = 5'd8;  end
            2'd2: begin core_x = a_q[7:0];  core_y = b_q[15:8]; shift = 5'd8;  end
            2'd3: begin core_x = a_q[15:8]; core_y = b_q[15:8]; shift = 5'd16; end
            default: ;
        endcase
        term_now = {16'b0, prod16} << shift;
        term_q   = {16'b0, prod_q} << shift_q;
        // With the registered core, the sum trails the core by one pass; prod_q is zeroed on accept.
        acc_add  = acc + ((REG_CORE != 0) ? term_q : term_now);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pass      <= 2'd0;
            acc       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            prod_q    <= '0;
            shift_q   <= '0;
            out_valid <= 1'b0;
            p         <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        a_q      <= a;
                        b_q      <= b;
                        acc      <= '0;
                        pass     <= 2'd0;
                        prod_q   <= '0;
                        shift_q  <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= MUL;
                    end
                end
                MUL: begin
                    pass <= pass + 2'd1;
                    acc  <= acc_add;
                    if (REG_CORE != 0) begin
                        prod_q  <= prod16;
                        shift_q <= shift;
                    end
                    if (pass == 2'd3) begin
                        if (REG_CORE != 0) begin
                            state <= FLUSH;
                        end else begin
                            p         <= acc_add;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                FLUSH: begin
                    acc       <= acc_add;
                    p         <= acc_add;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_mult16_core8.sv
// Bench drives two instances (REG_CORE=0 and 1) independently, checked against plain a*b arithmetic.
`timescale 1ns/1ps
module tb_seq_mult16_core8;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [15:0] a         [2];
    logic [15:0] b         [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] p         [2];
    logic        busy      [2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_mult16_core8 #(.REG_CORE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[0]), .b(b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .p(p[0]), .busy(busy[0]));

    seq_mult16_core8 #(.REG_CORE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[1]), .b(b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .p(p[1]), .busy(busy[1]));

    function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y);
        return 32'(x) * 32'(y);
    endfunction

    // Entered and left at a negedge; returns the time of the accepting posedge.
    task automatic send(input int d, input logic [15:0] av, input logic [15:0] bv,
                        input bit hold, output time t_acc, output bit ok);
        a[d] = av; b[d] = bv; in_valid[d] = 1'b1; ok = 1'b0; t_acc = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (in_ready[d]) begin
                ok = 1'b1;
                @(posedge clk); t_acc = $time;
                @(negedge clk);
            end else begin
                @(negedge clk);
            end
        end
        if (!hold) in_valid[d] = 1'b0;
    endtask

    task automatic recv(input int d, input int stall, output logic [31:0] pv,
                        output time t_first, output bit ok);
        int st = stall;
        out_ready[d] = 1'b0; ok = 1'b0; t_first = 0; pv = '0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (out_valid[d] && t_first == 0) t_first = $time;
            if (out_valid[d] && st == 0) begin
                out_ready[d] = 1'b1; pv = p[d]; ok = 1'b1;
                @(posedge clk);
                @(negedge clk);
                out_ready[d] = 1'b0;
            end else begin
                if (out_valid[d]) st--;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (in_ready[d] !== 1'b0 || out_valid[d] !== 1'b0 || p[d] !== 32'h0 || busy[d] !== 1'b0) begin
                fails++;
                $display("FAIL reset_state d=%0d got rdy=%b vld=%b p=%h busy=%b exp 0/0/0/0",
                         d, in_ready[d], out_valid[d], p[d], busy[d]);
            end
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (in_ready[d] !== 1'b0) begin
                fails++; $display("FAIL reset_release_rdy d=%0d got %b exp 0", d, in_ready[d]);
            end
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (in_ready[d] !== 1'b1) begin
                fails++; $display("FAIL first_edge_rdy d=%0d got %b exp 1", d, in_ready[d]);
            end
        end
    endtask

    task automatic test_max_operands();
        time ta, tf; bit ok1, ok2; logic [31:0] pv; int lat;
        for (int d = 0; d < 2; d++) begin
            send(d, 16'hFFFF, 16'hFFFF, 1'b0, ta, ok1);
            recv(d, 0, pv, tf, ok2);
            lat = int'((tf + 5 - ta) / 10);
            tests++;
            if (!ok1 || !ok2 || pv !== 32'hFFFE0001) begin
                fails++; $display("FAIL max_product d=%0d got %h exp fffe0001 (ok %b%b)", d, pv, ok1, ok2);
            end
            tests++;
            if (lat != 5 + d) begin
                fails++; $display("FAIL latency d=%0d got %0d exp %0d", d, lat, 5 + d);
            end
        end
    endtask

    task automatic test_back_to_back();
        time ta, tf; bit ok1, ok2; logic [31:0] pv;
        for (int d = 0; d < 2; d++) begin
            send(d, 16'h1234, 16'h00AB, 1'b1, ta, ok1);
            a[d] = 16'h0000; b[d] = 16'hBEEF;
            recv(d, 0, pv, tf, ok2);
            tests++;
            if (!ok1 || !ok2 || pv !== 32'h000C28BC) begin
                fails++; $display("FAIL b2b_first d=%0d got %h exp 000c28bc", d, pv);
            end
            tests++;
            if (in_ready[d] !== 1'b1 || busy[d] !== 1'b0) begin
                fails++; $display("FAIL b2b_idle d=%0d got rdy=%b busy=%b exp 1/0", d, in_ready[d], busy[d]);
            end
            send(d, 16'h0000, 16'hBEEF, 1'b0, ta, ok1);
            recv(d, 0, pv, tf, ok2);
            tests++;
            if (!ok1 || !ok2 || pv !== 32'h0) begin
                fails++; $display("FAIL b2b_zero d=%0d got %h exp 00000000", d, pv);
            end
        end
    endtask

    task automatic test_stall();
        time ta, tf; bit ok1, ok2, seen, bad; logic [31:0] pv;
        for (int d = 0; d < 2; d++) begin
            send(d, 16'h0100, 16'h0100, 1'b0, ta, ok1);
            out_ready[d] = 1'b0; seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                if (out_valid[d]) seen = 1'b1; else @(negedge clk);
            end
            bad = !seen;
            for (int i = 0; i < 10; i++) begin
                if (p[d] !== 32'h00010000 || out_valid[d] !== 1'b1 || in_ready[d] !== 1'b0 || busy[d] !== 1'b1)
                    bad = 1'b1;
                @(negedge clk);
            end
            tests++;
            if (bad) begin
                fails++; $display("FAIL stall_hold d=%0d got p=%h vld=%b rdy=%b exp 00010000/1/0", d, p[d], out_valid[d], in_ready[d]);
            end
            recv(d, 0, pv, tf, ok2);
            tests++;
            if (!ok2 || pv !== 32'h00010000 || in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0) begin
                fails++; $display("FAIL stall_release d=%0d got p=%h rdy=%b vld=%b exp 00010000/1/0", d, pv, in_ready[d], out_valid[d]);
            end
        end
    endtask

    task automatic test_reset_mid();
        time ta, tf; bit ok1, ok2; logic [31:0] pv;
        for (int d = 0; d < 2; d++) begin
            send(d, 16'hABCD, 16'h1234, 1'b0, ta, ok1);
            repeat (2) @(negedge clk);
            rst_n = 1'b0;
            #1;
            tests++;
            if (out_valid[d] !== 1'b0 || p[d] !== 32'h0 || busy[d] !== 1'b0 || in_ready[d] !== 1'b0) begin
                fails++; $display("FAIL abort d=%0d got vld=%b p=%h busy=%b rdy=%b exp 0/0/0/0", d, out_valid[d], p[d], busy[d], in_ready[d]);
            end
            @(negedge clk); rst_n = 1'b1;
            @(negedge clk);
            send(d, 16'd3, 16'd5, 1'b0, ta, ok1);
            recv(d, 0, pv, tf, ok2);
            tests++;
            if (!ok1 || !ok2 || pv !== 32'd15) begin
                fails++; $display("FAIL after_abort d=%0d got %h exp 0000000f", d, pv);
            end
        end
    endtask

    task automatic test_latched_operands();
        time ta, tf; bit ok1, ok2, bad; logic [31:0] pv, exp;
        for (int d = 0; d < 2; d++) begin
            exp = model(16'h1357, 16'h2468);
            send(d, 16'h1357, 16'h2468, 1'b0, ta, ok1);
            bad = 1'b0;
            for (int i = 0; i < 3; i++) begin
                a[d] = 16'($urandom); b[d] = 16'($urandom); in_valid[d] = 1'b1;
                if (in_ready[d] !== 1'b0) bad = 1'b1;
                @(negedge clk);
            end
            in_valid[d] = 1'b0;
            tests++;
            if (bad) begin
                fails++; $display("FAIL busy_not_ready d=%0d got rdy=1 exp 0", d);
            end
            recv(d, 0, pv, tf, ok2);
            tests++;
            if (!ok1 || !ok2 || pv !== exp) begin
                fails++; $display("FAIL latched d=%0d got %h exp %h", d, pv, exp);
            end
        end
    endtask

    task automatic test_random();
        time ta, tf; bit ok1, ok2; logic [31:0] pv, exp;
        logic [15:0] av, bv;
        logic [31:0] q[$];
        int n_acc, n_res, errs;
        for (int d = 0; d < 2; d++) begin
            n_acc = 0; n_res = 0; errs = 0;
            for (int n = 0; n < 1200; n++) begin
                av = 16'($urandom); bv = 16'($urandom);
                case ($urandom_range(0, 7))
                    0: av = 16'h0000;
                    1: bv = 16'hFFFF;
                    2: begin av = 16'hFFFF; bv = 16'hFFFF; end
                    default: ;
                endcase
                repeat ($urandom_range(0, 2)) @(negedge clk);
                if ($urandom_range(0, 3) == 0) out_ready[d] = 1'b1;
                send(d, av, bv, 1'b0, ta, ok1);
                if (ok1) begin n_acc++; q.push_back(model(av, bv)); end
                recv(d, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0, pv, tf, ok2);
                if (ok2) begin
                    n_res++;
                    exp = (q.size() > 0) ? q.pop_front() : 32'hDEADBEEF;
                    tests++;
                    if (pv !== exp) begin
                        fails++; errs++;
                        if (errs < 5) $display("FAIL random_prod d=%0d got %h exp %h", d, pv, exp);
                    end
                end
            end
            tests++;
            if (n_acc != 1200 || n_res != n_acc || q.size() != 0) begin
                fails++; $display("FAIL random_counts d=%0d got acc=%0d res=%0d exp 1200/1200", d, n_acc, n_res);
            end
            q.delete();
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0; a[d] = '0; b[d] = '0; out_ready[d] = 1'b0;
        end
        test_reset();
        test_max_operands();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_latched_operands();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
